// File: rtl/pipe_wb_skid_stage_pkg.sv
// rtl/pipe_wb_skid_stage_pkg.sv - shared pipeline widths, state encoding and entry layout
package pipe_wb_skid_stage_pkg;

  localparam int WORD_WIDTH = 64;
  localparam int REG_SIZE   = 5;
  localparam logic [WORD_WIDTH-1:0] ZEROWORD = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // Stored entry is packed as {valid, we, waddr, data}.
  function automatic int entry_w(input int data_w, input int addr_w);
    return 2 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/pipe_wb_skid_stage_if.sv
// rtl/pipe_wb_skid_stage_if.sv - valid/ready writeback entry stream
interface pipe_wb_skid_stage_if
  import pipe_wb_skid_stage_pkg::*;
#(
  parameter int DATA_W = WORD_WIDTH,
  parameter int ADDR_W = REG_SIZE
);
  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] data;

  modport master (output valid, we, waddr, data, input ready);
  modport slave  (input valid, we, waddr, data, output ready);
endinterface

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one {valid, we, waddr, data} entry with load and clear
module pipe_entry_reg
  import pipe_wb_skid_stage_pkg::*;
#(
  parameter int DATA_W = WORD_WIDTH,
  parameter int ADDR_W = REG_SIZE
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              clr,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_waddr,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic              q_we,
  output logic [ADDR_W-1:0] q_waddr,
  output logic [DATA_W-1:0] q_data
);
  localparam int EW = entry_w(DATA_W, ADDR_W);

  logic [EW-1:0] ent;

  // Clear drops only the valid bit so the last payload stays visible.
  always_ff @(posedge clk) begin
    if (rst)
      ent <= '0;
    else if (clr)
      ent[EW-1] <= 1'b0;
    else if (ld)
      ent <= {1'b1, d_we, d_waddr, d_data};
  end

  assign {q_valid, q_we, q_waddr, q_data} = ent;

endmodule

// File: rtl/pipe_wb_skid_stage.sv
// rtl/pipe_wb_skid_stage.sv - memory/writeback stage register with 2-entry skid and forwarding
module pipe_wb_skid_stage
  import pipe_wb_skid_stage_pkg::*;
#(
  parameter int DATA_W        = WORD_WIDTH,
  parameter int ADDR_W        = REG_SIZE,
  parameter int ZERO_REG_SKIP = 1
)(
  input  logic                clk,
  input  logic                rst,
  pipe_wb_skid_stage_if.slave  up,
  pipe_wb_skid_stage_if.master dn,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   fwd_addr,
  output logic                fwd_hit,
  output logic [DATA_W-1:0]   fwd_data,
  output logic [1:0]          occupancy
);
  skid_state_e state, state_nxt;

  logic              main_valid, main_we, skid_valid, skid_we;
  logic [ADDR_W-1:0] main_waddr, skid_waddr;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              in_ready, push, pop;
  logic              main_ld, main_from_skid, main_clr, skid_ld, skid_clr;

  assign push = up.valid & in_ready;
  assign pop  = main_valid & dn.ready;

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_EMPTY;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush)
      state_nxt = ST_EMPTY;
    else begin
      case (state)
        ST_EMPTY: if (push) state_nxt = ST_ONE;
        ST_ONE: begin
          if (push & ~pop)      state_nxt = ST_TWO;
          else if (pop & ~push) state_nxt = ST_EMPTY;
        end
        ST_TWO:   if (pop) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // in_ready depends only on registered state, never on dn.ready.
  always_comb begin
    in_ready       = (state != ST_TWO) & ~rst;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    main_clr       = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: main_ld = push;
        ST_ONE: begin
          main_ld  = push & pop;
          skid_ld  = push & ~pop;
          main_clr = pop & ~push;
        end
        ST_TWO: begin
          main_ld        = pop;
          main_from_skid = pop;
          skid_clr       = pop;
        end
        default: ;
      endcase
    end
  end

  pipe_entry_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .ld      (main_ld),
    .clr     (main_clr),
    .d_we    (main_from_skid ? skid_we    : up.we),
    .d_waddr (main_from_skid ? skid_waddr : up.waddr),
    .d_data  (main_from_skid ? skid_data  : up.data),
    .q_valid (main_valid),
    .q_we    (main_we),
    .q_waddr (main_waddr),
    .q_data  (main_data)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .ld      (skid_ld),
    .clr     (skid_clr),
    .d_we    (up.we),
    .d_waddr (up.waddr),
    .d_data  (up.data),
    .q_valid (skid_valid),
    .q_we    (skid_we),
    .q_waddr (skid_waddr),
    .q_data  (skid_data)
  );

  assign up.ready  = in_ready;
  assign dn.valid  = main_valid;
  assign dn.we     = main_valid & main_we;
  assign dn.waddr  = main_waddr;
  assign dn.data   = main_data;

  assign fwd_hit   = main_valid & main_we & (main_waddr == fwd_addr)
                   & ~((ZERO_REG_SKIP != 0) && (fwd_addr == '0));
  assign fwd_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  a_skid_needs_main: assert property (@(posedge clk) disable iff (rst) skid_valid |-> main_valid);
  a_occ_max:         assert property (@(posedge clk) disable iff (rst) occupancy != 2'd3);
  a_no_push_full:    assert property (@(posedge clk) disable iff (rst) !(skid_ld && state == ST_TWO));

endmodule

// File: tb/tb_pipe_wb_skid_stage.sv
// tb/tb_pipe_wb_skid_stage.sv - randomized scoreboard bench for pipe_wb_skid_stage
module tb_pipe_wb_skid_stage;
  import pipe_wb_skid_stage_pkg::*;

  localparam int DW = 64;
  localparam int AW = 5;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [AW-1:0] fwd_addr = '0;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [1:0]    occupancy;

  pipe_wb_skid_stage_if #(.DATA_W(DW), .ADDR_W(AW)) up_if ();
  pipe_wb_skid_stage_if #(.DATA_W(DW), .ADDR_W(AW)) dn_if ();

  always #5 clk = ~clk;

  pipe_wb_skid_stage #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG_SKIP(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .up        (up_if),
    .dn        (dn_if),
    .flush     (flush),
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .occupancy (occupancy)
  );

  ent_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   mon_en = 0;
  bit   last_acc = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // Reference model: a bounded FIFO of depth 2, emptied by reset or flush.
  always @(posedge clk) begin
    bit   push, pop;
    ent_t e;
    push = up_if.valid && !rst && (q.size() < 2);
    pop  = (q.size() > 0) && dn_if.ready;
    last_acc = push;
    e.we = up_if.we;
    e.waddr = up_if.waddr;
    e.data = up_if.data;
    if (rst || flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    if (rst) mon_en = 1;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_v, hit;
      exp_v = q.size() > 0;
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("in_ready", 64'(up_if.ready), 64'((q.size() < 2) && !rst));
      chk("out_valid", 64'(dn_if.valid), 64'(exp_v));
      hit = 0;
      if (exp_v) begin
        chk("out_we", 64'(dn_if.we), 64'(q[0].we));
        chk("out_waddr", 64'(dn_if.waddr), 64'(q[0].waddr));
        chk("out_data", dn_if.data, q[0].data);
        hit = q[0].we && (q[0].waddr == fwd_addr) && (fwd_addr != 0);
      end else begin
        chk("out_we_idle", 64'(dn_if.we), 64'd0);
      end
      chk("fwd_hit", 64'(fwd_hit), 64'(hit));
      if (hit) chk("fwd_data", fwd_data, q[0].data);
    end
  end

  task automatic step(input bit v, input logic [DW-1:0] d, input bit we, input logic [AW-1:0] wa,
                      input bit ordy, input bit fl, input bit r, input logic [AW-1:0] fa);
    up_if.valid = v;
    up_if.data  = d;
    up_if.we    = we;
    up_if.waddr = wa;
    dn_if.ready = ordy;
    flush       = fl;
    rst         = r;
    fwd_addr    = fa;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    @(negedge clk);
    chk({tag, "_data"}, dn_if.data, ZEROWORD);
    chk({tag, "_waddr"}, 64'(dn_if.waddr), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit            v, we, ordy, fl, r;
    logic [DW-1:0] d;
    logic [AW-1:0] wa, fa;

    up_if.valid = 0; up_if.data = '0; up_if.we = 0; up_if.waddr = '0;
    dn_if.ready = 0;

    step(0, 64'h0, 0, 0, 0, 0, 1, 0);
    step(0, 64'h0, 0, 0, 0, 0, 1, 0);
    check_cleared("reset");

    step(1, 64'h1111_0000_2222_0001, 1, 5, 1, 0, 0, 5);
    step(0, 64'h0, 0, 0, 1, 0, 0, 5);
    step(0, 64'h0, 0, 0, 1, 0, 0, 0);

    step(1, 64'hAAAA_0000_0000_0003, 1, 3, 0, 0, 0, 3);
    step(1, 64'hBBBB_0000_0000_0004, 1, 4, 0, 0, 0, 4);
    step(0, 64'h0, 0, 0, 0, 0, 0, 3);
    step(0, 64'h0, 0, 0, 1, 0, 0, 3);
    step(0, 64'h0, 0, 0, 1, 0, 0, 4);
    step(0, 64'h0, 0, 0, 1, 0, 0, 0);

    step(1, 64'hAAAA_1111_0000_0003, 1, 3, 0, 0, 0, 0);
    step(1, 64'hBBBB_1111_0000_0004, 1, 4, 0, 0, 0, 0);
    step(1, 64'hCCCC_1111_0000_000C, 1, 12, 0, 1, 0, 0);
    step(0, 64'h0, 0, 0, 1, 0, 0, 12);
    step(0, 64'h0, 0, 0, 1, 0, 0, 12);

    step(1, 64'hDDDD_0000_0000_0007, 1, 7, 0, 0, 0, 7);
    step(0, 64'h0, 0, 0, 0, 0, 0, 7);
    step(0, 64'h0, 0, 0, 0, 0, 0, 8);
    step(0, 64'h0, 0, 0, 0, 1, 0, 0);
    step(1, 64'hEEEE_0000_0000_0000, 1, 0, 0, 0, 0, 0);
    step(0, 64'h0, 0, 0, 0, 0, 0, 0);
    step(0, 64'h0, 0, 0, 0, 1, 0, 0);

    step(1, 64'hFFFF_0000_0000_0009, 0, 9, 0, 0, 0, 9);
    step(0, 64'h0, 0, 0, 0, 0, 0, 9);
    step(0, 64'h0, 0, 0, 0, 1, 0, 9);

    step(1, 64'h0123_4567_89AB_CDEF, 1, 1, 0, 0, 0, 1);
    step(1, 64'hFEDC_BA98_7654_3210, 1, 2, 0, 0, 0, 2);
    step(0, 64'h0, 0, 0, 0, 0, 1, 1);
    check_cleared("midrst");
    step(1, 64'h5555_6666_7777_8888, 1, 6, 1, 0, 0, 6);
    step(0, 64'h0, 0, 0, 1, 0, 0, 6);

    for (int i = 0; i < 32; i++)
      step(1, {$urandom, $urandom}, 1'($urandom), 5'($urandom_range(0, 7)), 1, 0, 0, 5'($urandom_range(0, 7)));

    v = 0; d = '0; we = 0; wa = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!(v && !last_acc)) begin
        v  = $urandom_range(0, 9) < 7;
        d  = {$urandom, $urandom};
        we = 1'($urandom);
        wa = 5'($urandom_range(0, 7));
      end
      ordy = $urandom_range(0, 9) < 6;
      fl   = $urandom_range(0, 15) == 0;
      r    = $urandom_range(0, 63) == 0;
      fa   = 5'($urandom_range(0, 7));
      step(v, d, we, wa, ordy, fl, r, fa);
    end

    step(0, 64'h0, 0, 0, 1, 0, 0, 0);
    step(0, 64'h0, 0, 0, 1, 0, 0, 0);
    step(0, 64'h0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
